// File: rtl/wav_gen_param.sv
// Parametrised waveform generator: an NCO phase accumulator feeds a
// registered triangle/square/saw/sine shaper (sine from an external
// quarter-wave ROM), and the selected sample is scaled by a linear
// attack/sustain/release envelope. Phase to wout latency is 3 clocks.
module wav_gen_param #(
  parameter int NBIT_PHASE   = 16,
  parameter int NBIT_WAV     = 8,
  parameter int NBIT_ENV     = 8,
  parameter int NBIT_WAV_OUT = 14,
  parameter int ENV_DIV      = 256
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [NBIT_PHASE-1:0]   inc_in,
  input  logic                    inc_valid_in,
  input  logic                    note_on_in,
  input  logic [1:0]              wsel,
  input  logic [NBIT_WAV-1:0]     duty_in,
  input  logic [NBIT_ENV-1:0]     env_rate_in,
  output logic [NBIT_WAV-3:0]     sin_rom_addr,
  input  logic [NBIT_WAV-2:0]     sin_rom_data,
  output logic [NBIT_WAV_OUT-1:0] wout,
  output logic                    wout_valid,
  output logic                    env_busy
);

  localparam int W     = NBIT_WAV;
  localparam int PRE_W = (ENV_DIV > 1) ? $clog2(ENV_DIV) : 1;

  localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(ENV_DIV - 1);
  localparam logic [NBIT_ENV-1:0] GAIN_MAX = '1;
  // +MX, -MX and the saw value -MX-1 that gets clamped, as W-bit patterns
  localparam logic [W-1:0] MX_U     = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] NEG_MX_U = {1'b1, {(W-2){1'b0}}, 1'b1};
  localparam logic [W-1:0] MIN_U    = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_ATTACK,
    S_SUSTAIN,
    S_RELEASE
  } env_state_e;

  // Envelope and NCO state
  env_state_e              state_q, state_d;
  logic [NBIT_ENV-1:0]     gain_q, gain_d;
  logic [PRE_W-1:0]        presc_q, presc_d;
  logic                    busy_q, busy_d;
  logic [NBIT_PHASE-1:0]   inc_q, inc_d;
  logic [NBIT_PHASE-1:0]   phase_q, phase_d;

  // Stage 1: raw shapes, sine sign and valid
  logic [W-1:0]            tri_q, tri_d;
  logic [W-1:0]            squ_q, squ_d;
  logic [W-1:0]            saw_q, saw_d;
  logic                    neg_q, neg_d;
  logic                    v1_q;

  // Stage 2: selected wave and valid
  logic [W-1:0]            wave_q, wave_d;
  logic                    v2_q;

  // Stage 3: enveloped output
  logic [NBIT_WAV_OUT-1:0] wout_q, wout_d;
  logic                    wout_valid_q;

  // Envelope working signals
  logic [NBIT_ENV:0]       gain_sum;
  logic [NBIT_ENV:0]       gain_diff;
  logic                    env_step;

  // Shaper working signals
  logic [W-1:0]            p;
  logic [W-2:0]            tri_t;
  logic [W-1:0]            saw_raw;
  logic [W-1:0]            sin_w;
  logic signed [W+NBIT_ENV:0] prod;
  logic [W-1:0]            w_scaled;

  // Envelope FSM next state, gain update and prescaler
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    state_d   = state_q;
    gain_d    = gain_q;
    presc_d   = presc_q;
    gain_sum  = {1'b0, gain_q} + {1'b0, env_rate_in};
    gain_diff = {1'b0, gain_q} - {1'b0, env_rate_in};
    env_step  = (presc_q == PRE_LAST);

    // Gate changes are checked before any step in the same cycle.
    unique case (state_q)
      S_IDLE: begin
        if (note_on_in) state_d = S_ATTACK;
      end
      S_ATTACK: begin
        if (!note_on_in) begin
          state_d = S_RELEASE;
        end else if (env_rate_in == '0) begin
          gain_d  = GAIN_MAX;
          state_d = S_SUSTAIN;
        end else if (env_step) begin
          if (gain_sum >= {1'b0, GAIN_MAX}) begin
            gain_d  = GAIN_MAX;
            state_d = S_SUSTAIN;
          end else begin
            gain_d = gain_sum[NBIT_ENV-1:0];
          end
        end
      end
      S_SUSTAIN: begin
        if (!note_on_in) state_d = S_RELEASE;
      end
      S_RELEASE: begin
        if (note_on_in) begin
          state_d = S_ATTACK;
        end else if (env_rate_in == '0) begin
          gain_d  = '0;
          state_d = S_IDLE;
        end else if (env_step) begin
          // Borrow out or an exact zero both end the note.
          if (gain_diff[NBIT_ENV] || (gain_diff[NBIT_ENV-1:0] == '0)) begin
            gain_d  = '0;
            state_d = S_IDLE;
          end else begin
            gain_d = gain_diff[NBIT_ENV-1:0];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // The prescaler restarts on every transition and sleeps in IDLE.
    if ((state_d != state_q) || (state_q == S_IDLE) || env_step) begin
      presc_d = '0;
    end else begin
      presc_d = presc_q + PRE_W'(1);
    end

    busy_d = (state_d != S_IDLE);
  end

  // Phase accumulator, increment load and stage-1 shaping
  always_comb begin
    inc_d   = inc_valid_in ? inc_in : inc_q;
    phase_d = (state_q == S_IDLE) ? '0 : phase_q + inc_q;

    p = phase_q[NBIT_PHASE-1 -: W];

    // Saw: offset-binary to two's complement, clamped to be symmetric.
    saw_raw = {~p[W-1], p[W-2:0]};
    saw_d   = (saw_raw == MIN_U) ? NEG_MX_U : saw_raw;

    // Triangle: fold the upper half, then map 0..MX onto -MX..+MX.
    // The W-bit wrap of 2t - MX yields the correct two's complement value.
    tri_t = p[W-1] ? ~p[W-2:0] : p[W-2:0];
    tri_d = {tri_t, 1'b0} - MX_U;

    squ_d = (p < duty_in) ? MX_U : NEG_MX_U;

    // Quarter-wave sine: mirror the address in odd quadrants, negate the
    // second half; the ROM answers one clock later.
    sin_rom_addr = p[W-2] ? ~p[W-3:0] : p[W-3:0];
    neg_d        = p[W-1];
  end

  // Stage-2 sine sign and waveform select, stage-3 envelope scaling
  always_comb begin
    sin_w = neg_q ? -{1'b0, sin_rom_data} : {1'b0, sin_rom_data};

    unique case (wsel)
      2'b00:   wave_d = tri_q;
      2'b01:   wave_d = squ_q;
      2'b10:   wave_d = saw_q;
      default: wave_d = sin_w;
    endcase

    // Gain is treated as an unsigned fraction of 2^NBIT_ENV.
    prod     = $signed(wave_q) * $signed({1'b0, gain_q});
    w_scaled = W'(prod >>> NBIT_ENV);

    wout_d = '0;
    if (v2_q) wout_d[NBIT_WAV_OUT-1 -: W] = w_scaled;
  end

  // State, accumulator and pipeline registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      gain_q       <= '0;
      presc_q      <= '0;
      busy_q       <= 1'b0;
      inc_q        <= '0;
      phase_q      <= '0;
      tri_q        <= '0;
      squ_q        <= '0;
      saw_q        <= '0;
      neg_q        <= 1'b0;
      v1_q         <= 1'b0;
      wave_q       <= '0;
      v2_q         <= 1'b0;
      wout_q       <= '0;
      wout_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values and the pipeline stages shift together.
      state_q      <= state_d;
      gain_q       <= gain_d;
      presc_q      <= presc_d;
      busy_q       <= busy_d;
      inc_q        <= inc_d;
      phase_q      <= phase_d;
      tri_q        <= tri_d;
      squ_q        <= squ_d;
      saw_q        <= saw_d;
      neg_q        <= neg_d;
      v1_q         <= busy_q;
      wave_q       <= wave_d;
      v2_q         <= v1_q;
      wout_q       <= wout_d;
      wout_valid_q <= v2_q;
    end
  end

  assign wout       = wout_q;
  assign wout_valid = wout_valid_q;
  assign env_busy   = busy_q;

endmodule

// File: tb/tb_wav_gen_param.sv
// Bench for wav_gen_param: directed phases plus randomized segments, checked
// every cycle against an arithmetic model of the waveform and envelope rules.
module tb_wav_gen_param;

  localparam int DIV = 4;
  localparam int M_IDLE = 0, M_ATTACK = 1, M_SUSTAIN = 2, M_RELEASE = 3;

  logic        clk;
  logic        rstn;
  logic [15:0] inc_in;
  logic        inc_valid_in;
  logic        note_on_in;
  logic [1:0]  wsel;
  logic [7:0]  duty_in;
  logic [7:0]  env_rate_in;
  logic [5:0]  sin_rom_addr;
  logic [6:0]  sin_rom_data;
  logic [13:0] wout;
  logic        wout_valid;
  logic        env_busy;

  int total = 0;
  int bad   = 0;

  wav_gen_param #(
    .NBIT_PHASE(16), .NBIT_WAV(8), .NBIT_ENV(8), .NBIT_WAV_OUT(14), .ENV_DIV(DIV)
  ) dut (
    .clk(clk), .rstn(rstn),
    .inc_in(inc_in), .inc_valid_in(inc_valid_in),
    .note_on_in(note_on_in), .wsel(wsel),
    .duty_in(duty_in), .env_rate_in(env_rate_in),
    .sin_rom_addr(sin_rom_addr), .sin_rom_data(sin_rom_data),
    .wout(wout), .wout_valid(wout_valid), .env_busy(env_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Quarter-wave sine ROM with one clock of read latency.
  int rom [64];
  initial sin_rom_data = '0;
  always @(posedge clk) sin_rom_data <= 7'(rom[sin_rom_addr]);

  // Reference model state and per-edge history ring.
  int m_mode, m_gain, m_tick, m_phase, m_inc;
  int n;
  int h_phase [16], h_busy [16], h_gain [16], h_duty [16], h_wsel [16];

  function automatic int ix(input int k);
    return k & 15;
  endfunction

  function automatic int sin_idx(input int p);
    int i;
    i = p % 64;
    if (((p / 64) % 2) == 1) i = 63 - i;
    return i;
  endfunction

  function automatic int wave_of(input int p, input int duty, input int sel);
    case (sel)
      0:       return (p < 128) ? 2 * p - 127 : 383 - 2 * p;
      1:       return (p < duty) ? 127 : -127;
      2:       return (p == 0) ? -127 : p - 128;
      default: return (p >= 128) ? -rom[sin_idx(p)] : rom[sin_idx(p)];
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_gain = 0; m_tick = 0; m_phase = 0; m_inc = 0;
    for (int i = 0; i < 16; i++) begin
      h_phase[i] = 0; h_busy[i] = 0; h_gain[i] = 0; h_duty[i] = 0; h_wsel[i] = 0;
    end
  endtask

  // One clock edge of the spec rules, using the inputs present at the edge.
  task automatic model_edge();
    int nm, ng, nt, np, rate;
    bit step;
    rate = int'(env_rate_in);
    np   = (m_mode == M_IDLE) ? 0 : (m_phase + m_inc) % 65536;
    nm   = m_mode;
    ng   = m_gain;
    step = (m_tick == DIV - 1);
    case (m_mode)
      M_IDLE:    if (note_on_in) nm = M_ATTACK;
      M_ATTACK: begin
        if (!note_on_in) nm = M_RELEASE;
        else if (rate == 0) begin ng = 255; nm = M_SUSTAIN; end
        else if (step) begin
          ng = m_gain + rate;
          if (ng >= 255) begin ng = 255; nm = M_SUSTAIN; end
        end
      end
      M_SUSTAIN: if (!note_on_in) nm = M_RELEASE;
      default: begin
        if (note_on_in) nm = M_ATTACK;
        else if (rate == 0) begin ng = 0; nm = M_IDLE; end
        else if (step) begin
          ng = m_gain - rate;
          if (ng <= 0) begin ng = 0; nm = M_IDLE; end
        end
      end
    endcase
    nt = (nm != m_mode || m_mode == M_IDLE) ? 0 : (m_tick + 1) % DIV;
    if (inc_valid_in) m_inc = int'(inc_in);
    m_mode = nm; m_gain = ng; m_tick = nt; m_phase = np;
    n++;
    h_phase[ix(n)] = np;
    h_busy[ix(n)]  = (nm != M_IDLE) ? 1 : 0;
    h_gain[ix(n)]  = ng;
    h_duty[ix(n)]  = int'(duty_in);
    h_wsel[ix(n)]  = int'(wsel);
  endtask

  // Compare all observable outputs against the model after edge n.
  task automatic check_cycle();
    int s;
    logic [13:0] exp_w;
    exp_w = '0;
    if (h_busy[ix(n - 3)] != 0) begin
      s = (wave_of((h_phase[ix(n - 3)] >> 8) & 255, h_duty[ix(n - 2)], h_wsel[ix(n - 1)])
           * h_gain[ix(n - 1)]) >>> 8;
      exp_w = 14'(s * 64);
    end
    check("env_busy", 32'(env_busy), 32'(h_busy[ix(n)]));
    check("wout_valid", 32'(wout_valid), 32'(h_busy[ix(n - 3)]));
    check("wout", 32'(wout), 32'(exp_w));
    check("sin_rom_addr", 32'(sin_rom_addr), 32'(sin_idx((h_phase[ix(n)] >> 8) & 255)));
    check("gain", 32'(dut.gain_q), 32'(h_gain[ix(n)]));
  endtask

  task automatic tick(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_cycle();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wout"}, 32'(wout), 32'd0);
    check({tag, "_wout_valid"}, 32'(wout_valid), 32'd0);
    check({tag, "_env_busy"}, 32'(env_busy), 32'd0);
    check({tag, "_rom_addr"}, 32'(sin_rom_addr), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++)
      rom[i] = $rtoi(127.0 * $sin(3.14159265358979 * (real'(i) + 0.5) / 128.0) + 0.5);
    n = 16;
    model_reset();
    inc_in = '0; inc_valid_in = 1'b0; note_on_in = 1'b0; wsel = 2'b00;
    duty_in = '0; env_rate_in = '0;

    // Asynchronous reset before any clock edge.
    rstn = 1'b1;
    #1 rstn = 1'b0;
    #1 check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    tick(3);

    // Saw at inc 0x0100 with instant attack.
    inc_in = 16'h0100; inc_valid_in = 1'b1; env_rate_in = 8'd0;
    wsel = 2'b10; note_on_in = 1'b1; duty_in = 8'h40;
    tick(1);
    inc_valid_in = 1'b0;
    tick(300);

    // Triangle, then square with duty 0x40 and duty 0.
    wsel = 2'b00;
    tick(300);
    wsel = 2'b01;
    tick(300);
    duty_in = 8'h00;
    tick(20);

    // Sine through the external ROM.
    wsel = 2'b11;
    tick(300);

    // Random shape, duty and increment changes while sustaining.
    for (int k = 0; k < 40; k++) begin
      wsel    = 2'($urandom_range(0, 3));
      duty_in = 8'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        inc_in = 16'($urandom); inc_valid_in = 1'b1;
      end
      tick(1);
      inc_valid_in = 1'b0;
      tick($urandom_range(2, 12));
    end

    // Release instantly to IDLE, then a stepped attack and release.
    inc_in = 16'h0100; inc_valid_in = 1'b1;
    note_on_in = 1'b0;
    tick(1);
    inc_valid_in = 1'b0;
    tick(8);
    env_rate_in = 8'd64; wsel = 2'b10; note_on_in = 1'b1;
    tick(24);
    note_on_in = 1'b0;
    tick(24);

    // Retrigger during release at gain 128.
    note_on_in = 1'b1;
    for (int i = 0; i < 40 && dut.gain_q != 8'd128; i++) tick(1);
    check("gain_reach_128", 32'(dut.gain_q), 32'd128);
    note_on_in = 1'b0;
    tick(1);
    note_on_in = 1'b1;
    tick(30);

    // Random gate and rate activity.
    for (int k = 0; k < 30; k++) begin
      note_on_in  = ~note_on_in;
      env_rate_in = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      wsel        = 2'($urandom_range(0, 3));
      tick($urandom_range(1, 40));
    end

    // Downward increment, then reset mid-note without a clock edge.
    note_on_in = 1'b1; env_rate_in = 8'd0;
    inc_in = 16'hFFFF; inc_valid_in = 1'b1;
    tick(1);
    inc_valid_in = 1'b0;
    tick(600);
    #2 rstn = 1'b0;
    #1 check_reset_outputs("midnote_reset");
    check("midnote_reset_gain", 32'(dut.gain_q), 32'd0);
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
    tick(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
